// File: rtl/data_memory_mc.sv
// data_memory_mc: byte-addressed multi-cycle data memory for the RISC-V datapath.
//   It supports every RV64I load/store size, with sign or zero extension on loads.
//   It flags misaligned and illegal accesses, and it answers LATENCY cycles after a request is accepted.
// Ports: clk, reset (synchronous, active-low), MemRead/MemWrite/Funct3/Mem_Addr/Write_Data (request),
//   Read_Data/Mem_Busy/Mem_Ready/Mem_Error (registered response).
// Option macro: DMEM_RESET_CLEAR_EN - when defined, reset also zeroes the whole storage array.
module data_memory_mc #(
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH_BYTES = 256,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [63:0]           Mem_Addr,
  input  logic [DATA_WIDTH-1:0] Write_Data,
  output logic [DATA_WIDTH-1:0] Read_Data,
  output logic                  Mem_Busy,
  output logic                  Mem_Ready,
  output logic                  Mem_Error
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   a_idx;
  logic [2:0]      a_f3;
  logic            a_wr;
  logic [63:0]     a_wdata;

  logic [7:0]      mem [DEPTH_BYTES];

  logic            req;
  logic            acc_err;
  logic            misalign;
  logic            illegal;
  logic [3:0]      nbytes;
  logic [63:0]     raw;
  logic [63:0]     ext;
  logic            commit;

  // Address bits above the array index only alias; they are intentionally dropped.
  logic            unused_addr_hi;
  assign unused_addr_hi = ^Mem_Addr[63:AW];

  assign req = MemRead | MemWrite;

  // Classify the captured access; this is evaluated while in WAIT.
  always_comb begin
    nbytes   = 4'd1 << a_f3[1:0];
    illegal  = (a_f3 == 3'b111) | (a_wr & a_f3[2]) |
               ((DATA_WIDTH == 32) & ((a_f3 == 3'b011) | (a_f3 == 3'b110)));
    misalign = 1'b0;
    case (a_f3[1:0])
      2'd1:    misalign = a_idx[0];
      2'd2:    misalign = |a_idx[1:0];
      2'd3:    misalign = |a_idx[2:0];
      default: misalign = 1'b0;
    endcase
    acc_err = illegal | misalign;
  end

  // Gather eight bytes from the access index.  Aligned accesses never wrap the
  // array, and any bytes beyond the access size are discarded by the extension step.
  always_comb begin
    raw = '0;
    for (int k = 0; k < 8; k++) begin
      raw[8*k +: 8] = mem[a_idx + AW'(k)];
    end
    case (a_f3)
      3'b000:  ext = {{56{raw[7]}},  raw[7:0]};
      3'b001:  ext = {{48{raw[15]}}, raw[15:0]};
      3'b010:  ext = {{32{raw[31]}}, raw[31:0]};
      3'b100:  ext = {56'd0, raw[7:0]};
      3'b101:  ext = {48'd0, raw[15:0]};
      3'b110:  ext = {32'd0, raw[31:0]};
      default: ext = raw;
    endcase
  end

  // The memory changes on the WAIT->RESP edge, and only for a good write.
  // A reset on that edge abandons the write.
  assign commit = reset && (state == WAIT) && (cnt == '0) && a_wr && !acc_err;

  always_ff @(posedge clk) begin
`ifdef DMEM_RESET_CLEAR_EN
    if (!reset) begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (commit) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < nbytes) mem[a_idx + AW'(k)] <= a_wdata[8*k +: 8];
      end
    end
`else
    if (commit) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < nbytes) mem[a_idx + AW'(k)] <= a_wdata[8*k +: 8];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      a_idx     <= '0;
      a_f3      <= '0;
      a_wr      <= 1'b0;
      a_wdata   <= '0;
      Read_Data <= '0;
      Mem_Busy  <= 1'b0;
      Mem_Ready <= 1'b0;
      Mem_Error <= 1'b0;
    end else begin
      case (state)
        // RESP accepts a new request exactly as IDLE does.
        // This gives one access every LATENCY+1 cycles.
        IDLE, RESP: begin
          Mem_Ready <= 1'b0;
          Mem_Error <= 1'b0;
          if (req) begin
            a_idx    <= Mem_Addr[AW-1:0];
            a_f3     <= Funct3;
            a_wr     <= MemWrite;  // write wins when both strobes are high
            a_wdata  <= 64'(Write_Data);
            cnt      <= CW'(LATENCY - 1);
            Mem_Busy <= 1'b1;
            state    <= WAIT;
          end else begin
            state    <= IDLE;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            Mem_Busy  <= 1'b0;
            Mem_Ready <= 1'b1;
            Mem_Error <= acc_err;
            if (!a_wr && !acc_err) Read_Data <= ext[DATA_WIDTH-1:0];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_mc.sv
// tb_data_memory_mc: directed and randomized checks of data_memory_mc against a byte-array model.
//   The model covers size, extension, alignment, legality, latency, pulse shape and reset behaviour.
// Ports: none (top-level bench).
module tb_data_memory_mc;

  localparam int DW  = 64;
  localparam int DEP = 256;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          MemRead = 1'b0;
  logic          MemWrite = 1'b0;
  logic [2:0]    Funct3 = 3'd0;
  logic [63:0]   Mem_Addr = 64'd0;
  logic [DW-1:0] Write_Data = '0;
  logic [DW-1:0] Read_Data;
  logic          Mem_Busy;
  logic          Mem_Ready;
  logic          Mem_Error;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mdl [DEP];
  logic [63:0] rd_mdl;

  data_memory_mc #(.DATA_WIDTH(DW), .DEPTH_BYTES(DEP), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
    .Mem_Addr(Mem_Addr), .Write_Data(Write_Data), .Read_Data(Read_Data),
    .Mem_Busy(Mem_Busy), .Mem_Ready(Mem_Ready), .Mem_Error(Mem_Error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] addr);
    int n = 1 << f3[1:0];
    int base = int'(addr % DEP);
    logic [63:0] v = 64'd0;
    for (int k = 0; k < n; k++) v = v | (64'(mdl[(base + k) % DEP]) << (8 * k));
    if (!f3[2] && n < 8 && v[8*n-1]) v = v - (64'd1 << (8 * n));
    return v;
  endfunction

  function automatic bit model_err(input bit wr, input logic [2:0] f3, input logic [63:0] addr);
    int n = 1 << f3[1:0];
    bit ill = (f3 == 3'd7) || (wr && f3[2]) || (DW == 32 && (f3 == 3'd3 || f3 == 3'd6));
    return ill || ((addr % n) != 0);
  endfunction

  // One complete access from IDLE: request, latency, response pulse, and return to quiet.
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wd, input string tag);
    bit exp_err;
    int n;
    exp_err = model_err(wr, f3, addr);
    if (!exp_err) begin
      if (wr) begin
        for (int k = 0; k < (1 << f3[1:0]); k++)
          mdl[int'((addr + 64'(k)) % DEP)] = wd[8*k +: 8];
      end else begin
        rd_mdl = model_load(f3, addr);
      end
    end
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Funct3 = f3; Mem_Addr = addr; Write_Data = wd;
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    chk({tag, "_busy"}, 64'(Mem_Busy), 64'd1);
    n = 0;
    while (Mem_Ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
      if (Mem_Ready !== 1'b1 && n < LAT) chk({tag, "_busy_wait"}, 64'(Mem_Busy), 64'd1);
    end
    chk({tag, "_latency"}, 64'(n), 64'(LAT));
    chk({tag, "_busy_done"}, 64'(Mem_Busy), 64'd0);
    chk({tag, "_err"}, 64'(Mem_Error), 64'(exp_err));
    chk({tag, "_rdata"}, 64'(Read_Data), rd_mdl);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {62'd0, Mem_Ready, Mem_Error}, 64'd0);
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] d;
    logic [2:0]  f;
    bit          w;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", 64'(Read_Data), 64'd0);
    chk("rst_busy", 64'(Mem_Busy), 64'd0);
    chk("rst_ready", 64'(Mem_Ready), 64'd0);
    chk("rst_err", 64'(Mem_Error), 64'd0);
    rd_mdl = 64'd0;
    @(negedge clk); reset = 1'b1;

    // Give every byte a known value. Random upper address bits exercise aliasing.
    for (int i = 0; i < DEP / 8; i++) begin
      a = (64'($urandom) << 8) | 64'(8 * i);
      d = {$urandom, $urandom};
      access(1'b0, 1'b1, 3'd3, a, d, "fill");
    end

    // Full doubleword round trip
    access(1'b0, 1'b1, 3'd3, 64'd8, 64'h1122334455667788, "sd8");
    access(1'b1, 1'b0, 3'd3, 64'd8, 64'd0, "ld8");
    chk("ld8_const", 64'(Read_Data), 64'h1122334455667788);

    // Byte store with signed and unsigned loads
    access(1'b0, 1'b1, 3'd0, 64'd3, 64'h80, "sb3");
    access(1'b1, 1'b0, 3'd0, 64'd3, 64'd0, "lb3");
    chk("lb3_const", 64'(Read_Data), 64'hFFFFFFFFFFFFFF80);
    access(1'b1, 1'b0, 3'd4, 64'd3, 64'd0, "lbu3");
    chk("lbu3_const", 64'(Read_Data), 64'h0000000000000080);
    access(1'b1, 1'b0, 3'd1, 64'd2, 64'd0, "lh2");
    chk("lh2_upper", 64'(Read_Data[63:8]), 64'h00FFFFFFFFFFFF80);

    // Error accesses leave memory and Read_Data untouched
    access(1'b1, 1'b0, 3'd2, 64'd6, 64'd0, "lw6_mis");
    access(1'b0, 1'b1, 3'd3, 64'd4, 64'hFFFFFFFFFFFFFFFF, "sd4_mis");
    access(1'b0, 1'b1, 3'd4, 64'd8, 64'h55, "sbu_ill");
    access(1'b1, 1'b0, 3'd7, 64'd0, 64'd0, "f3_7_ill");
    access(1'b1, 1'b0, 3'd3, 64'd0, 64'd0, "ld0_after_err");
    access(1'b1, 1'b0, 3'd3, 64'd8, 64'd0, "ld8_after_err");

    // Both strobes high behave as a write; then check aliasing
    access(1'b1, 1'b1, 3'd2, 64'd16, 64'hDEADBEEF, "rw_sw16");
    access(1'b1, 1'b0, 3'd6, 64'd16, 64'd0, "lwu16");
    chk("lwu16_const", 64'(Read_Data), 64'h00000000DEADBEEF);
    access(1'b1, 1'b0, 3'd6, 64'd16 + 64'(DEP), 64'd0, "lwu16_wrap");
    chk("lwu16_wrap_const", 64'(Read_Data), 64'h00000000DEADBEEF);

    // Randomized mix
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~64'(7);
      d = {$urandom, $urandom};
      access(!w || ($urandom_range(0, 1) == 1), w, f, a, d, "rand");
    end

    // Held request: one accept per LAT+1 cycles, single-cycle pulses
    rd_mdl = model_load(3'd3, 64'd8);
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'd3; Mem_Addr = 64'd8;
    for (int i = 0; i < 3 * (LAT + 1); i++) begin
      @(posedge clk); #1;
      chk("held_ready", 64'(Mem_Ready), 64'((i % (LAT + 1)) == LAT));
      chk("held_busy", 64'(Mem_Busy), 64'((i % (LAT + 1)) != LAT));
      if (Mem_Ready === 1'b1) chk("held_rdata", 64'(Read_Data), rd_mdl);
    end
    MemRead = 1'b0;
    @(posedge clk); #1;
    chk("held_release", {62'd0, Mem_Ready, Mem_Busy}, 64'd0);

    // Reset while a write is in WAIT
    @(negedge clk);
    MemWrite = 1'b1; Funct3 = 3'd3; Mem_Addr = 64'd0; Write_Data = 64'hAAAAAAAAAAAAAAAA;
    @(posedge clk); #1;
    MemWrite = 1'b0;
    chk("rw_busy", 64'(Mem_Busy), 64'd1);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("rw_rst_rdata", 64'(Read_Data), 64'd0);
    chk("rw_rst_busy", 64'(Mem_Busy), 64'd0);
    chk("rw_rst_ready", 64'(Mem_Ready), 64'd0);
    chk("rw_rst_err", 64'(Mem_Error), 64'd0);
    rd_mdl = 64'd0;
`ifdef DMEM_RESET_CLEAR_EN
    for (int i = 0; i < DEP; i++) mdl[i] = 8'h00;
`endif
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("rw_after_ready", 64'(Mem_Ready), 64'd0);
    access(1'b1, 1'b0, 3'd3, 64'd0, 64'd0, "ld0_post_rst");
    access(1'b1, 1'b0, 3'd3, 64'd8, 64'd0, "ld8_post_rst");
    access(1'b1, 1'b0, 3'd6, 64'd16, 64'd0, "lwu16_post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
